// File: rtl/asm18_uart_host.sv
// Host-side UART master for the asm18 debug/load protocol: serialises one command
// as 8N1 bytes, then collects the ack or read-data reply (or times out).
module asm18_uart_host #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_SIZE    = 18,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic                 clk_50M,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_error,
  output logic                 uart_tx_pin,
  input  logic                 uart_rx_pin
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int TW   = $clog2(TIMEOUT_CLKS);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t               state, state_next;
  logic                 alive;
  logic [2:0]           op_q;
  logic [WORD_SIZE-1:0] addr_q, data_q;
  logic                 tx_q;
  logic [CW-1:0]        tx_cnt;
  logic [3:0]           tx_bit;
  logic [2:0]           tx_idx, tx_last;
  logic [7:0]           tx_byte;
  logic                 tx_bit_end, tx_all_end;
  logic [TW-1:0]        to_cnt;
  logic [1:0]           rsp_idx;
  logic [15:0]          rx_word;
  logic                 rsp_error_q;
  logic [WORD_SIZE-1:0] rsp_data_q;
  logic                 done_err;
  logic [WORD_SIZE-1:0] done_data;
  logic                 handshake, is_read, is_write;

  // Receiver registers
  logic                 rx_s1, rx_s2, rx_s3;
  logic                 rx_busy;
  logic [CW-1:0]        rx_cnt;
  logic [3:0]           rx_bit;
  logic [7:0]           rx_shift;
  logic                 rx_sample, rx_ok, rx_ferr;

  assign cmd_ready   = alive && (state == S_IDLE);
  assign handshake   = cmd_valid && cmd_ready;
  assign rsp_valid   = (state == S_DONE);
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign uart_tx_pin = tx_q;

  assign is_write = (op_q == 3'd0) || (op_q == 3'd1);
  assign is_read  = (op_q == 3'd2) || (op_q == 3'd3);
  assign tx_last  = is_write ? 3'd6 : (is_read ? 3'd3 : 3'd0);

  always_comb begin
    tx_byte = 8'h00;
    unique case (tx_idx)
      3'd0:    tx_byte = {5'b0, op_q} + 8'd1;
      3'd1:    tx_byte = addr_q[7:0];
      3'd2:    tx_byte = addr_q[15:8];
      3'd3:    tx_byte = {6'b0, addr_q[17:16]};
      3'd4:    tx_byte = data_q[7:0];
      3'd5:    tx_byte = data_q[15:8];
      3'd6:    tx_byte = {6'b0, data_q[17:16]};
      default: tx_byte = 8'h00;
    endcase
  end

  assign tx_bit_end = (tx_cnt == CW'(CLKS_PER_BIT - 1));
  assign tx_all_end = (state == S_SEND) && tx_bit_end && (tx_bit == 4'd9) && (tx_idx == tx_last);

  // The start bit is re-checked half a bit after the edge; later samples are a full bit apart.
  assign rx_sample = rx_busy && (rx_cnt == ((rx_bit == 4'd0) ? CW'(HALF - 1) : CW'(CLKS_PER_BIT - 1)));
  assign rx_ok     = rx_sample && (rx_bit == 4'd9) && rx_s2;
  assign rx_ferr   = rx_sample && (rx_bit == 4'd9) && !rx_s2;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    done_err   = 1'b0;
    done_data  = '0;
    unique case (state)
      S_IDLE: if (handshake) begin
        if (cmd_op == 3'd7) begin
          state_next = S_DONE;
          done_err   = 1'b1;
        end else begin
          state_next = S_SEND;
        end
      end
      S_SEND: if (tx_all_end) state_next = S_WAIT;
      S_WAIT: begin
        if (rx_ferr) begin
          state_next = S_DONE;
          done_err   = 1'b1;
        end else if (rx_ok && is_read) begin
          if (rsp_idx == 2'd2) begin
            state_next = S_DONE;
            done_data  = WORD_SIZE'({rx_shift[1:0], rx_word});
          end
        end else if (rx_ok) begin
          state_next = S_DONE;
          done_err   = (rx_shift != 8'h5A);
        end else if (to_cnt == TW'(TIMEOUT_CLKS - 1)) begin
          state_next = S_DONE;
          done_err   = 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state       <= S_IDLE;
      alive       <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_q        <= 1'b1;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_idx      <= '0;
      to_cnt      <= '0;
      rsp_idx     <= '0;
      rx_word     <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state <= state_next;
      alive <= 1'b1;
      if (handshake) begin
        op_q   <= cmd_op;
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        if (cmd_op != 3'd7) begin
          tx_q   <= 1'b0;
          tx_cnt <= '0;
          tx_bit <= '0;
          tx_idx <= '0;
        end
      end
      if (state == S_SEND) begin
        if (!tx_bit_end) begin
          tx_cnt <= tx_cnt + CW'(1);
        end else begin
          tx_cnt <= '0;
          if (tx_bit != 4'd9) begin
            tx_bit <= tx_bit + 4'd1;
            tx_q   <= (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
          end else if (tx_idx == tx_last) begin
            tx_q    <= 1'b1;
            to_cnt  <= '0;
            rsp_idx <= '0;
          end else begin
            tx_idx <= tx_idx + 3'd1;
            tx_bit <= '0;
            tx_q   <= 1'b0;
          end
        end
      end
      if (state == S_WAIT) begin
        to_cnt <= to_cnt + TW'(1);
        if (rx_ok && is_read) begin
          rsp_idx <= rsp_idx + 2'd1;
          if (rsp_idx == 2'd0) rx_word[7:0]  <= rx_shift;
          if (rsp_idx == 2'd1) rx_word[15:8] <= rx_shift;
        end
      end
      if (state_next == S_DONE) begin
        rsp_data_q  <= done_data;
        rsp_error_q <= done_err;
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1 <= uart_rx_pin;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (!rx_busy) begin
        if (rx_s3 && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_sample) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_busy <= 1'b0;
          else       rx_bit  <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
        end else begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_asm18_uart_host.sv
// Bench for asm18_uart_host: a UART line model decodes TX bytes and plays replies,
// with expected bytes, data, errors and cycle timing derived from the protocol rules.
module tb_asm18_uart_host;
  localparam int CPB = 4;
  localparam int TO  = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [17:0] cmd_addr = '0, cmd_data = '0;
  logic        rx_pin = 1'b1;
  logic        cmd_ready, rsp_valid, rsp_error, uart_tx_pin;
  logic [17:0] rsp_data;

  int total = 0, bad = 0;
  int cyc = 0;
  int rsp_count = 0, last_rsp_cyc = -1;
  logic [17:0] last_rsp_data;
  logic        last_rsp_err;

  asm18_uart_host #(.CLKS_PER_BIT(CPB), .WORD_SIZE(18), .TIMEOUT_CLKS(TO)) dut (
    .clk_50M(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .uart_tx_pin(uart_tx_pin), .uart_rx_pin(rx_pin));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rsp_count++;
      last_rsp_cyc  = cyc;
      last_rsp_data = rsp_data;
      last_rsp_err  = rsp_error;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [17:0] a, input logic [17:0] d,
                        input bit hold, output int hs, output bit ok);
    int g = 0;
    ok = 1'b1;
    hs = cyc;
    while (cmd_ready !== 1'b1 && g < 50) begin tick; g++; end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait: cmd_ready=%b expected 1 within 50 cycles", cmd_ready);
      ok = 1'b0;
      return;
    end
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    tick;
    hs = cyc;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop, output int c0);
    c0 = cyc;
    rx_pin = 1'b0;
    repeat (CPB) tick;
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (CPB) tick;
    end
    rx_pin = stop;
    repeat (CPB) tick;
    rx_pin = 1'b1;
  endtask

  // kind: 0 normal reply, 2 ack with stop bit 0, 3 no reply, 4 glitch then normal reply
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [17:0] a,
                         input logic [17:0] d, input int kind, input logic [23:0] reply);
    logic [7:0]  exp_tx[$];
    logic [9:0]  got;
    bit          is_rd, is_wr, ok;
    int          hs, base, s, c0, g, n, ai, di, w, exp_cyc;
    logic        exp_err;
    logic [17:0] exp_data;
    is_wr = (op <= 3'd1);
    is_rd = (op == 3'd2) || (op == 3'd3);
    ai = int'(a); di = int'(d);
    exp_tx.push_back(8'(int'(op) + 1));
    if (is_wr || is_rd) begin
      exp_tx.push_back(8'(ai % 256)); exp_tx.push_back(8'((ai / 256) % 256)); exp_tx.push_back(8'(ai / 65536));
    end
    if (is_wr) begin
      exp_tx.push_back(8'(di % 256)); exp_tx.push_back(8'((di / 256) % 256)); exp_tx.push_back(8'(di / 65536));
    end
    n = exp_tx.size();
    base = rsp_count;
    do_cmd(op, a, d, 1'b0, hs, ok);
    if (!ok) return;
    total++;
    if (uart_tx_pin !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s handshake: tx=%b ready=%b expected tx=0 ready=0", name, uart_tx_pin, cmd_ready);
    end
    for (int i = 0; i < n; i++) begin
      g = 0;
      while (uart_tx_pin !== 1'b0 && g < 60) begin tick; g++; end
      s = cyc;
      total++;
      if (uart_tx_pin !== 1'b0 || s != hs + 10 * CPB * i) begin
        bad++;
        $display("FAIL %s tx_start[%0d]: at cycle %0d expected %0d", name, i, s, hs + 10 * CPB * i);
        if (uart_tx_pin !== 1'b0) return;
      end
      tick; tick;
      got = '0;
      got[0] = uart_tx_pin;
      for (int b = 1; b <= 9; b++) begin
        repeat (CPB) tick;
        got[b] = uart_tx_pin;
      end
      total++;
      if (got !== {1'b1, exp_tx[i], 1'b0}) begin
        bad++;
        $display("FAIL %s tx_byte[%0d]: frame=%b expected %b", name, i, got, {1'b1, exp_tx[i], 1'b0});
      end
    end
    exp_cyc = hs + 10 * CPB * n + TO;
    exp_err = 1'b1;
    exp_data = '0;
    if (kind != 3) begin
      repeat (4) tick;
      if (kind == 4) begin
        rx_pin = 1'b0; tick; rx_pin = 1'b1;
        repeat (10) tick;
      end
      if (is_rd) begin
        for (int k = 0; k < 3; k++) send_rx(reply[8*k +: 8], 1'b1, c0);
        w = int'(reply[7:0]) + 256 * int'(reply[15:8]) + 65536 * (int'(reply[23:16]) % 4);
        exp_data = 18'(w);
        exp_err = 1'b0;
      end else begin
        send_rx(reply[7:0], kind != 2, c0);
        exp_err = (kind == 2) || (reply[7:0] != 8'h5A);
      end
      exp_cyc = c0 + 10 * CPB + CPB / 2 - 1;
    end
    g = 0;
    while (rsp_count == base && g < 300) begin tick; g++; end
    total++;
    if (rsp_count == base) begin
      bad++;
      $display("FAIL %s rsp_wait: no rsp_valid within 300 cycles, expected one", name);
      return;
    end
    repeat (3) tick;
    total++;
    if (rsp_count != base + 1) begin
      bad++;
      $display("FAIL %s rsp_pulses: saw %0d cycles of rsp_valid expected 1", name, rsp_count - base);
    end
    total++;
    if (last_rsp_err !== exp_err || last_rsp_data !== exp_data) begin
      bad++;
      $display("FAIL %s rsp_value: err=%b data=%h expected err=%b data=%h", name, last_rsp_err, last_rsp_data, exp_err, exp_data);
    end
    total++;
    if (last_rsp_cyc != exp_cyc) begin
      bad++;
      $display("FAIL %s rsp_timing: rsp_valid at cycle %0d expected %0d", name, last_rsp_cyc, exp_cyc);
    end
    total++;
    if (rsp_error !== exp_err || rsp_data !== exp_data || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s rsp_hold: err=%b data=%h ready=%b expected err=%b data=%h ready=1", name, rsp_error, rsp_data, cmd_ready, exp_err, exp_data);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick;
    total++;
    if (uart_tx_pin !== 1'b1 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 18'd0 || rsp_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: tx=%b ready=%b valid=%b data=%h err=%b expected 1 0 0 0 0", uart_tx_pin, cmd_ready, rsp_valid, rsp_data, rsp_error);
    end
    reset = 1'b0;
    tick;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_reserved_op;
    int hs, base;
    bit ok, line_ok;
    base = rsp_count;
    do_cmd(3'd7, 18'($urandom), 18'($urandom), 1'b1, hs, ok);
    if (!ok) return;
    total++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_data !== 18'd0 || uart_tx_pin !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reserved_op: valid=%b err=%b data=%h tx=%b ready=%b expected 1 1 0 1 0", rsp_valid, rsp_error, rsp_data, uart_tx_pin, cmd_ready);
    end
    tick;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL overlap_handshake: cmd_ready=%b expected 1 (valid during rsp not accepted)", cmd_ready);
    end
    cmd_valid = 1'b0;
    line_ok = 1'b1;
    repeat (10) begin tick; if (uart_tx_pin !== 1'b1) line_ok = 1'b0; end
    total++;
    if (!line_ok || rsp_count != base + 1) begin
      bad++;
      $display("FAIL reserved_quiet: line_idle=%b rsp_pulses=%0d expected idle=1 pulses=1", line_ok, rsp_count - base);
    end
  endtask

  task automatic test_reset_mid_frame;
    int hs, base;
    bit ok;
    base = rsp_count;
    do_cmd(3'd1, 18'h2AAAA, 18'h15555, 1'b0, hs, ok);
    if (!ok) return;
    while (cyc < hs + 2 * 10 * CPB + 5) tick;
    reset = 1'b1;
    tick;
    total++;
    if (uart_tx_pin !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: tx=%b ready=%b expected tx=1 ready=0", uart_tx_pin, cmd_ready);
    end
    reset = 1'b0;
    tick;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_release: cmd_ready=%b expected 1", cmd_ready);
    end
    repeat (20) tick;
    total++;
    if (rsp_count != base) begin
      bad++;
      $display("FAIL reset_mid_no_rsp: saw %0d rsp_valid cycles expected 0", rsp_count - base);
    end
    run_cmd("read_after_reset", 3'd3, 18'($urandom), 18'd0, 0, 24'($urandom));
  endtask

  task automatic test_stray_and_glitch;
    int base, c0;
    base = rsp_count;
    send_rx(8'h5A, 1'b1, c0);
    repeat (10) tick;
    total++;
    if (rsp_count != base || cmd_ready !== 1'b1 || uart_tx_pin !== 1'b1) begin
      bad++;
      $display("FAIL stray_rx: pulses=%0d ready=%b tx=%b expected 0 1 1", rsp_count - base, cmd_ready, uart_tx_pin);
    end
    run_cmd("glitch_then_ack", 3'd6, 18'd0, 18'd0, 4, 24'h00005A);
  endtask

  task automatic test_random;
    logic [2:0] op;
    int k;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 6));
      k  = $urandom_range(0, 3);
      if (op == 3'd2 || op == 3'd3)
        run_cmd("random_read", op, 18'($urandom), 18'($urandom), (k == 3) ? 3 : 0, 24'($urandom));
      else if (k == 0)
        run_cmd("random_ack", op, 18'($urandom), 18'($urandom), 0, 24'h00005A);
      else if (k == 1)
        run_cmd("random_anyack", op, 18'($urandom), 18'($urandom), 0, 24'($urandom));
      else
        run_cmd("random_err", op, 18'($urandom), 18'($urandom), k, 24'h00005A);
    end
  endtask

  initial begin
    test_reset;
    run_cmd("write_data", 3'd1, 18'h00123, 18'h3ABCD, 0, 24'h00005A);
    run_cmd("read_code", 3'd2, 18'h3FFFF, 18'h00000, 0, 24'hFE1234);
    run_cmd("bad_ack", 3'd6, 18'd0, 18'd0, 0, 24'h000000);
    run_cmd("framing", 3'd6, 18'd0, 18'd0, 2, 24'h00005A);
    run_cmd("timeout", 3'd4, 18'd0, 18'd0, 3, 24'h000000);
    test_reserved_op;
    test_reset_mid_frame;
    test_stray_and_glitch;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asm18_uart_host.md
# asm18_uart_host

Host-side UART master for the asm18 debug/load protocol. It turns single commands from local FPGA logic into 8N1 byte frames on `uart_tx_pin`, then collects the target's reply on `uart_rx_pin`. Typical users are a self-test harness or a second board driving an asm18 target: code/data word writes, word reads, processor reset control and continue. One command is outstanding at a time; every command ends with exactly one response pulse, either data/ack or error.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); integer ≥ 4.
- `WORD_SIZE`, 18: width of address and data words; fixed at 18 for the wire format.
- `TIMEOUT_CLKS`, 1000000: cycles allowed for the full response after the last TX stop bit.
- `clk_50M  in  1`: the only clock.
- `reset  in  1`: synchronous, active-high reset.
- `cmd_valid  in  1`: command request.
- `cmd_ready  out  1`: high only in IDLE. The handshake completes when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op  in  3`: 0 WRITE_CODE, 1 WRITE_DATA, 2 READ_CODE, 3 READ_DATA, 4 RESET_ASSERT, 5 RESET_RELEASE, 6 CONTINUE, 7 reserved.
- `cmd_addr  in  18`: word address, captured at the handshake.
- `cmd_data  in  18`: write data, captured at the handshake.
- `rsp_valid  out  1`: one-cycle pulse marking command completion.
- `rsp_data  out  18`: read data; 0 for non-read commands and for errors. Held until the next `rsp_valid`.
- `rsp_error  out  1`: qualifies `rsp_valid`; held with `rsp_data`.
- `uart_tx_pin  out  1`: serial out; idles high.
- `uart_rx_pin  in  1`: serial in, asynchronous; passes through a 2-flop synchronizer.

## Operation
- **Frame format:** 8N1, LSB first: start bit 0, 8 data bits, stop bit 1.
- **Word encoding:** a word is sent as 3 bytes, low byte first: `w[7:0]`, `w[15:8]`, then `{6'b0, w[17:16]}`.
- **Opcode byte:** `cmd_op + 1`, i.e. 0x01 to 0x07.
- **TX sequence:**
  - writes: op, addr×3, data×3 (7 bytes);
  - reads: op, addr×3 (4 bytes);
  - ops 4 to 6: op only (1 byte).
- **Expected response:**
  - writes and ops 4 to 6: one ack byte, 0x5A;
  - reads: 3 data bytes in word encoding. Bits 7:2 of the 3rd byte are ignored.
- **States:**
  - IDLE: `cmd_ready`=1.
  - Handshake: op 7 goes to DONE with error. Any other op captures addr/data and goes to SEND.
  - SEND: a byte index steps through the sequence. Bytes go back-to-back with no idle bits. After the last stop bit, go to WAIT_RSP.
  - WAIT_RSP: the receiver assembles bytes, and a timeout counter runs.
  - DONE: one cycle; `rsp_valid`=1; then return to IDLE.
- **RX sampling:** a falling edge on the synchronized rx starts a byte. The start bit is re-checked at `CLKS_PER_BIT/2` (integer division) and must still read 0, otherwise the edge is a glitch and is ignored. Each data bit and the stop bit is sampled `CLKS_PER_BIT` later than the previous sample.
- **Error conditions:** `rsp_error`=1 and `rsp_data`=0 when any of these occur:
  - stop bit sampled as 0 (framing error), which aborts the response immediately;
  - ack byte ≠ 0x5A;
  - timeout, i.e. `TIMEOUT_CLKS` cycles in WAIT_RSP without a complete response;
  - op 7.
- **Stray RX:** bytes arriving while not in WAIT_RSP are discarded. Bytes beyond the expected count cannot occur, because the FSM leaves WAIT_RSP on the last one.

## Timing
- **Reset values:**
  - `uart_tx_pin`=1, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_error`=0;
  - FSM in IDLE; all counters 0.
  - `cmd_ready` rises on the first edge with `reset` low.
- **Reset mid-operation:** `uart_tx_pin` returns to 1 at that edge and the partial frame is truncated. No `rsp_valid` is produced for the aborted command. The receiver restarts its search for a start bit.
- **Handshake to line:** if the handshake happens at edge N, `cmd_ready`=0 and `uart_tx_pin`=0 (start bit) from edge N+1.
- **TX duration:** each byte lasts exactly `10*CLKS_PER_BIT` cycles. A write's TX therefore occupies `70*CLKS_PER_BIT` cycles.
- **Response completion:** `rsp_valid` is asserted the cycle after the mid-stop-bit sample of the last response byte. `cmd_ready` is 1 on the following cycle.
- **Timeout:** counted from the first cycle of WAIT_RSP. `rsp_valid` fires on cycle `TIMEOUT_CLKS`+1.
- **Reserved op:** `rsp_valid` fires at N+1 with `rsp_error`=1. No line activity occurs.
- **Overlapping handshake:** `cmd_valid` during a cycle with `rsp_valid`=1 is not accepted, because `cmd_ready`=0 in that cycle.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `TIMEOUT_CLKS`=200, with a bench UART model on the line.
- **WRITE_DATA:** addr 0x00123, data 0x3ABCD. TX bytes 0x02, 0x23, 0x01, 0x00, 0xCD, 0xAB, 0x03 back-to-back in 280 cycles. Model replies 0x5A → `rsp_valid` pulse with error=0 and data=0.
- **READ_CODE:** addr 0x3FFFF. TX 0x03, 0xFF, 0xFF, 0x03. Model replies 0x34, 0x12, 0xFE → `rsp_data`=0x21234, error=0.
- **Bad ack and framing:**
  - CONTINUE: TX 0x07; reply 0x00 → `rsp_error`=1.
  - Repeated with a reply whose stop bit is 0 → `rsp_error`=1 right after the stop sample.
- **Timeout and reserved op:**
  - RESET_ASSERT with no reply → `rsp_valid`/`rsp_error` exactly 201 cycles after WAIT_RSP entry.
  - op 7 → error pulse at N+1, `uart_tx_pin` stays 1.
- **Reset mid-frame:** assert `reset` during the 3rd TX byte of a write. Next edge: `uart_tx_pin`=1 and `cmd_ready`=0. Release reset: `cmd_ready`=1; a new READ_DATA completes correctly. The bench checks that no `rsp_valid` occurred for the aborted command.
- **Stray and glitch RX:**
  - a stray 0x5A in IDLE is ignored;
  - a 1-cycle low glitch on rx during WAIT_RSP is rejected;
  - the following valid 0x5A ack completes without error.
